// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel clock-enable / strobe generator on refclk.
// Each channel has a runtime-programmable period, high time and phase.
// Any accepted write to a valid channel realigns every channel and re-arms
// the locked indication.
//
// state  | meaning
// -------+---------------------------------------------------------------
// APPLY  | one cycle: counters preload from phase, outputs forced low
// SETTLE | counters run, waiting LOCK_CYCLES cycles before declaring lock
// LOCKED | counters run, locked asserted
module clk_div_gen #(
  parameter int NUM_CLKS    = 2,
  parameter int CH_W        = 1,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_PERIOD  = 2
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CNT_W-1:0]    cfg_phase,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_stb,
  output logic                locked
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H    = CNT_W'(DEF_PERIOD / 2);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_APPLY  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SET_W-1:0]   settle_q;

  logic [CNT_W-1:0]   period_q [NUM_CLKS];
  logic [CNT_W-1:0]   high_q   [NUM_CLKS];
  logic [CNT_W-1:0]   phase_q  [NUM_CLKS];
  logic [CNT_W-1:0]   cnt_q    [NUM_CLKS];
  logic [CNT_W-1:0]   cnt_d    [NUM_CLKS];

  logic [NUM_CLKS-1:0] clk_d;
  logic [NUM_CLKS-1:0] stb_d;

  logic               chan_ok;
  logic               accept;
  logic               wr_hit;
  logic [CNT_W-1:0]   per_san;
  logic [CNT_W-1:0]   pha_san;

  // Handshake is open whenever the channels are not being realigned.
  assign cfg_ready = (state_q != ST_APPLY);
  assign locked    = (state_q == ST_LOCKED);

  // Writes to channels that do not exist complete the handshake but are dropped.
  assign chan_ok = ({1'b0, cfg_chan} < (CH_W + 1)'(NUM_CLKS));
  assign accept  = cfg_valid & cfg_ready;
  assign wr_hit  = accept & chan_ok;

  // A period below 2 cannot toggle; a phase at or beyond the period folds to 0.
  assign per_san = (cfg_period < MIN_P) ? MIN_P : cfg_period;
  assign pha_san = (cfg_phase >= per_san) ? '0 : cfg_phase;

  // State register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_APPLY;
    else        state_q <= state_d;
  end

  // Next-state logic: a valid write always restarts from APPLY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (wr_hit)                    state_d = ST_APPLY;
        else if (settle_q == SET_LAST) state_d = ST_LOCKED;
      end
      ST_LOCKED: if (wr_hit) state_d = ST_APPLY;
      default:   state_d = ST_APPLY;
    endcase
  end

  // Settle timer counts SETTLE cycles from 0; cleared whenever not settling.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                    settle_q <= '0;
    else if (state_q != ST_SETTLE) settle_q <= '0;
    else                           settle_q <= settle_q + SET_ONE;
  end

  // Per-channel configuration registers, defaults restored on reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        period_q[i] <= DEF_P;
        high_q[i]   <= DEF_H;
        phase_q[i]  <= '0;
      end
    end else if (wr_hit) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        if (cfg_chan == CH_W'(i)) begin
          period_q[i] <= per_san;
          high_q[i]   <= cfg_high;
          phase_q[i]  <= pha_san;
        end
      end
    end
  end

  // Next counter value and the outputs derived from it. Preloading with
  // (P - F) mod P puts the first wrap to 0 exactly F cycles into SETTLE.
  always_comb begin
    clk_d = '0;
    stb_d = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == ST_APPLY)
        cnt_d[i] = (phase_q[i] == '0) ? '0 : (period_q[i] - phase_q[i]);
      else if (cnt_q[i] >= (period_q[i] - ONE))
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + ONE;
      clk_d[i] = (state_d != ST_APPLY) && (cnt_d[i] < high_q[i]);
      stb_d[i] = (state_d != ST_APPLY) && (cnt_d[i] == '0) &&
                 (high_q[i] != '0) && (high_q[i] < period_q[i]);
    end
  end

  // Counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLKS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLKS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Registered outputs so the waveforms never glitch.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      outclk     <= '0;
      outclk_stb <= '0;
    end else begin
      outclk     <= clk_d;
      outclk_stb <= stb_d;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed testbench for clk_div_gen (2 channels, 2-bit channel select).
module tb_clk_div_gen;

  logic        refclk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_chan;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [15:0] cfg_phase;
  logic [1:0]  outclk;
  logic [1:0]  outclk_stb;
  logic        locked;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int mp [2];
  int mh [2];
  int mf [2];

  clk_div_gen #(
    .NUM_CLKS(2), .CH_W(2), .CNT_W(16), .LOCK_CYCLES(16), .DEF_PERIOD(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_stb(outclk_stb), .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Expected {stb[1:0], clk[1:0]} at SETTLE-relative cycle kk.
  function automatic logic [3:0] exp_wave(input int kk);
    logic [1:0] c;
    logic [1:0] s;
    int cnt;
    c = '0;
    s = '0;
    for (int i = 0; i < 2; i++) begin
      cnt  = (kk + mp[i] - mf[i]) % mp[i];
      c[i] = (cnt < mh[i]);
      s[i] = (cnt == 0) && (mh[i] != 0) && (mh[i] < mp[i]);
    end
    return {s, c};
  endfunction

  task automatic set_model(input int ch, input int p, input int h, input int f);
    mp[ch] = p;
    mh[ch] = h;
    mf[ch] = f;
  endtask

  task automatic model_defaults();
    set_model(0, 2, 1, 0);
    set_model(1, 2, 1, 0);
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
    k++;
  endtask

  // Presents one write at a negedge; returns at the negedge after acceptance.
  task automatic cfg_write(input logic [1:0] ch, input int p, input int h, input int f);
    cfg_chan   = ch;
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(f);
    cfg_valid  = 1'b1;
    @(posedge refclk);
    @(negedge refclk);
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    cfg_valid = 0; cfg_chan = 0; cfg_period = 0; cfg_high = 0; cfg_phase = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_defaults();
    repeat (3) @(negedge refclk);
    n_checks++;
    if ({outclk_stb, outclk, locked, cfg_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {outclk_stb, outclk, locked, cfg_ready});
    end
    rst_n = 1'b1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_apply_ready: got %b expected 0", cfg_ready);
    end
    k = -1;
    repeat (17) begin
      step();
      e = exp_wave(k);
      n_checks++;
      if ({outclk_stb, outclk} !== e) begin
        n_fail++;
        $display("FAIL reset_wave k=%0d: got %b expected %b", k, {outclk_stb, outclk}, e);
      end
      n_checks++;
      if (locked !== (k >= 16)) begin
        n_fail++;
        $display("FAIL reset_locked k=%0d: got %b expected %b", k, locked, (k >= 16));
      end
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_locked: got %b expected 1", cfg_ready);
    end
  endtask

  task automatic test_program();
    logic [3:0] e;
    cfg_write(0, 5, 2, 0);
    set_model(0, 5, 2, 0);
    n_checks++;
    if ({locked, cfg_ready, outclk, outclk_stb} !== 6'b0) begin
      n_fail++;
      $display("FAIL prog_apply: got %b expected 000000", {locked, cfg_ready, outclk, outclk_stb});
    end
    k = -1;
    step();
    e = exp_wave(k);
    n_checks++;
    if ({outclk_stb, outclk} !== e) begin
      n_fail++;
      $display("FAIL prog_wave_first k=%0d: got %b expected %b", k, {outclk_stb, outclk}, e);
    end
    cfg_write(1, 10, 5, 3);
    set_model(1, 10, 5, 3);
    n_checks++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_apply2: got locked=%b ready=%b expected 0 0", locked, cfg_ready);
    end
    k = -1;
    repeat (20) begin
      step();
      e = exp_wave(k);
      n_checks++;
      if ({outclk_stb, outclk} !== e) begin
        n_fail++;
        $display("FAIL prog_wave k=%0d: got %b expected %b", k, {outclk_stb, outclk}, e);
      end
      n_checks++;
      if (locked !== (k >= 16)) begin
        n_fail++;
        $display("FAIL prog_locked k=%0d: got %b expected %b", k, locked, (k >= 16));
      end
    end
  endtask

  task automatic test_edges();
    int ep [4] = '{1, 4, 4, 4};
    int eh [4] = '{1, 0, 7, 2};
    int ef [4] = '{0, 0, 0, 9};
    int sp [4] = '{2, 4, 4, 4};
    logic [3:0] e;
    for (int j = 0; j < 4; j++) begin
      cfg_write(0, ep[j], eh[j], ef[j]);
      set_model(0, sp[j], eh[j], 0);
      n_checks++;
      if (locked !== 1'b0) begin
        n_fail++;
        $display("FAIL edge_apply_locked case=%0d: got %b expected 0", j, locked);
      end
      k = -1;
      repeat (8) begin
        step();
        e = exp_wave(k);
        n_checks++;
        if ({outclk_stb, outclk} !== e) begin
          n_fail++;
          $display("FAIL edge_wave case=%0d k=%0d: got %b expected %b", j, k, {outclk_stb, outclk}, e);
        end
      end
    end
  endtask

  task automatic test_bad_chan();
    int guard;
    logic [3:0] e;
    guard = 0;
    while (locked !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_chan_lock_wait: got locked=%b expected 1 within 40 cycles", locked);
    end
    cfg_chan = 2'd3; cfg_period = 16'd3; cfg_high = 16'd1; cfg_phase = 16'd0;
    cfg_valid = 1'b1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_chan_ready: got %b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    repeat (6) begin
      e = exp_wave(k);
      n_checks++;
      if (locked !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_chan_locked k=%0d: got %b expected 1", k, locked);
      end
      n_checks++;
      if ({outclk_stb, outclk} !== e) begin
        n_fail++;
        $display("FAIL bad_chan_wave k=%0d: got %b expected %b", k, {outclk_stb, outclk}, e);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    cfg_chan = 2'd0; cfg_period = 16'd3; cfg_high = 16'd1; cfg_phase = 16'd0;
    cfg_valid = 1'b1;
    @(posedge refclk);
    @(negedge refclk);
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_apply: got %b expected 0", cfg_ready);
    end
    cfg_chan = 2'd1; cfg_period = 16'd4; cfg_high = 16'd2; cfg_phase = 16'd1;
    @(posedge refclk);
    @(negedge refclk);
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_settle: got %b expected 1", cfg_ready);
    end
    @(posedge refclk);
    @(negedge refclk);
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_apply: got ready=%b locked=%b expected 0 0", cfg_ready, locked);
    end
    set_model(0, 3, 1, 0);
    set_model(1, 4, 2, 1);
    k = -1;
    repeat (18) begin
      step();
      e = exp_wave(k);
      n_checks++;
      if ({outclk_stb, outclk} !== e) begin
        n_fail++;
        $display("FAIL b2b_wave k=%0d: got %b expected %b", k, {outclk_stb, outclk}, e);
      end
      n_checks++;
      if (locked !== (k >= 16)) begin
        n_fail++;
        $display("FAIL b2b_locked k=%0d: got %b expected %b", k, locked, (k >= 16));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    cfg_write(0, 5, 2, 0);
    set_model(0, 5, 2, 0);
    k = -1;
    step();
    e = exp_wave(k);
    n_checks++;
    if ({outclk_stb, outclk} !== e) begin
      n_fail++;
      $display("FAIL rstmid_pre_wave: got %b expected %b", {outclk_stb, outclk}, e);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({outclk_stb, outclk, locked, cfg_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b expected 000000", {outclk_stb, outclk, locked, cfg_ready});
    end
    @(negedge refclk);
    rst_n = 1'b1;
    model_defaults();
    k = -1;
    repeat (17) begin
      step();
      e = exp_wave(k);
      n_checks++;
      if ({outclk_stb, outclk} !== e) begin
        n_fail++;
        $display("FAIL rstmid_wave k=%0d: got %b expected %b", k, {outclk_stb, outclk}, e);
      end
      n_checks++;
      if (locked !== (k >= 16)) begin
        n_fail++;
        $display("FAIL rstmid_locked k=%0d: got %b expected %b", k, locked, (k >= 16));
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_edges();
    test_bad_chan();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
